// File: rtl/bus_initiator.sv
// Byte-wide bus initiator: turns 8/16-bit read/write commands into single-byte
// peripheral strobes. Optional `BUS_INITIATOR_WAIT_EN adds a bus_wait stall input.
module bus_initiator #(
    parameter int unsigned RD_LATENCY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_wide,
    input  logic [23:0] cmd_address,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        bus_write,
    output logic        bus_read,
    output logic [23:0] bus_address_out,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in
`ifdef BUS_INITIATOR_WAIT_EN
    ,
    input  logic        bus_wait
`endif
);

    typedef enum logic [2:0] {IDLE, STROBE, HOLD, RWAIT, DONE} state_t;

    localparam logic [1:0] LAST_WAIT = (RD_LATENCY == 0) ? 2'd0 : 2'(RD_LATENCY - 1);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic        wide_q, wide_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        idx_q, idx_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] rdata_q, rdata_d;

    logic        ready_c;
    logic        sample;
    logic        stall;
    logic [23:0] cur_addr;
    logic [7:0]  sel_byte;

`ifdef BUS_INITIATOR_WAIT_EN
    assign stall = bus_wait;
`else
    assign stall = 1'b0;
`endif

    // 24-bit add wraps naturally, so the high byte of 0xFFFFFF lands at 0x000000
    assign cur_addr  = addr_q + 24'(idx_q);
    assign sel_byte  = idx_q ? wdata_q[15:8] : wdata_q[7:0];
    // Gated by reset so ready drops immediately while reset is held
    assign cmd_ready = ready_c & reset;
    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            wide_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= 1'b0;
            cnt_q   <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            wide_q  <= wide_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        write_d         = write_q;
        wide_d          = wide_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        idx_d           = idx_q;
        cnt_d           = cnt_q;
        lo_d            = lo_q;
        rdata_d         = rdata_q;
        ready_c         = 1'b0;
        rsp_valid       = 1'b0;
        bus_write       = 1'b0;
        bus_read        = 1'b0;
        bus_address_out = '0;
        bus_data_out    = '0;
        sample          = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (cmd_valid) begin
                    write_d = cmd_write;
                    wide_d  = cmd_wide;
                    addr_d  = cmd_address;
                    wdata_d = cmd_wdata;
                    idx_d   = 1'b0;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                bus_address_out = cur_addr;
                if (write_q) begin
                    bus_write    = 1'b1;
                    bus_data_out = sel_byte;
                    if (!stall) state_d = HOLD;
                end else begin
                    bus_read = 1'b1;
                    if (!stall) begin
                        if (RD_LATENCY == 0) begin
                            sample = 1'b1;
                        end else begin
                            cnt_d   = '0;
                            state_d = RWAIT;
                        end
                    end
                end
            end
            HOLD: begin
                // Address/data stay valid one cycle past the strobe for late-latching peripherals
                bus_address_out = cur_addr;
                bus_data_out    = sel_byte;
                if (wide_q && !idx_q) begin
                    idx_d   = 1'b1;
                    state_d = STROBE;
                end else begin
                    state_d = DONE;
                end
            end
            RWAIT: begin
                bus_address_out = cur_addr;
                bus_read        = 1'b1;
                if (cnt_q == LAST_WAIT) sample = 1'b1;
                else                    cnt_d  = cnt_q + 2'd1;
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (sample) begin
            if (wide_q && !idx_q) begin
                lo_d    = bus_data_in;
                idx_d   = 1'b1;
                state_d = STROBE;
            end else begin
                rdata_d = wide_q ? {bus_data_in, lo_q} : {8'h00, bus_data_in};
                state_d = DONE;
            end
        end
    end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 0, range 0-3: idle cycles between the read strobe cycle and the read-data sample edge.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a posedge.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_wide  input  1  1 = 16-bit access (two bytes), 0 = byte access.
REQ-008 SHALL have port cmd_address  input  24  byte address of the low byte.
REQ-009 SHALL have port cmd_wdata  input  16  write data; only [7:0] used when cmd_wide=0.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  16  read result; held until the next rsp_valid.
REQ-012 SHALL have port bus_write  output  1  peripheral write strobe.
REQ-013 SHALL have port bus_read  output  1  peripheral read enable.
REQ-014 SHALL have port bus_address_out  output  24  byte address driven to peripherals.
REQ-015 SHALL have port bus_data_out  output  8  write byte driven to peripherals.
REQ-016 SHALL have port bus_data_in  input  8  read byte returned combinationally by the addressed peripheral.

Function
REQ-017 SHALL implement FSM states IDLE, STROBE, HOLD, RWAIT, DONE.
REQ-018 SHALL drive cmd_ready high only in IDLE; on acceptance, SHALL register cmd_write, cmd_wide, cmd_address and cmd_wdata, select byte 0, and go to STROBE.
REQ-019 In STROBE, SHALL drive bus_address_out = captured address + byte index, modulo 2^24 (0xFFFFFF+1 wraps to 0x000000).
REQ-020 For writes in STROBE, SHALL drive bus_write=1 and bus_data_out = selected byte (low byte first), then go to HOLD.
REQ-021 In HOLD, SHALL hold the address and data with bus_write=0, so the peripheral's delayed write latch sees stable values.
REQ-022 For reads in STROBE, SHALL drive bus_read=1 and hold it through RWAIT; the low byte SHALL be read before the high byte.
REQ-023 For reads, SHALL sample bus_data_in at the posedge ending the cycle RD_LATENCY cycles after STROBE; with RD_LATENCY=0, SHALL sample at the end of STROBE and skip RWAIT.
REQ-024 After byte 0 of a wide access, SHALL select byte 1 and return to STROBE; after the last byte, SHALL go to DONE.
REQ-025 In DONE, SHALL pulse rsp_valid for exactly one cycle, then go to IDLE.
REQ-026 SHALL place a byte read in rsp_rdata as {8'h00, byte} and a wide read as {hi, lo}.
REQ-027 For writes, SHALL leave rsp_rdata unchanged.
REQ-028 Latency from acceptance edge to rsp_valid high: byte write 3 cycles; wide write 5 cycles; byte read 2+RD_LATENCY cycles; wide read 3+2*RD_LATENCY cycles.
REQ-029 Outside active phases, SHALL drive bus_write, bus_read, bus_address_out and bus_data_out to 0.
REQ-030 SHALL never assert bus_write and bus_read together.
REQ-031 SHALL ignore cmd_valid outside IDLE; back-to-back commands SHALL be accepted no earlier than the cycle after DONE.

Reset
REQ-032 While reset is low, SHALL force state=IDLE, cmd_ready=0, rsp_valid=0, rsp_rdata=0 and all bus outputs to 0, regardless of clk.
REQ-033 Reset asserted mid-access SHALL abort the command with no rsp_valid; the first cycle after deassertion SHALL be IDLE with cmd_ready=1.

Configuration
REQ-034 With macro BUS_INITIATOR_WAIT_EN defined, SHALL add port bus_wait (input, 1); while bus_wait=1 in STROBE, the FSM SHALL stay in STROBE with strobe, address and data held, extending latency by one cycle per wait cycle.
REQ-035 Without BUS_INITIATOR_WAIT_EN, SHALL omit port bus_wait, and the latencies in REQ-028 SHALL be exact.

Verification
REQ-036 Byte write 0x2030 data 0x86 -> bus_write high for exactly 1 cycle, address/data held 1 more cycle, rsp_valid 3 cycles after acceptance.
REQ-037 Wide read 0x2036 with bus model returning 0x34 then 0x12, RD_LATENCY=0 -> rsp_rdata=0x1234, addresses 0x2036 then 0x2037, rsp_valid at cycle 3.
REQ-038 Wide write at 0xFFFFFF data 0xBEEF -> byte 0xEF at 0xFFFFFF, then 0xBE at 0x000000.
REQ-039 RD_LATENCY=2 byte read of 0x2019 returning 0x31 -> bus_read high 3 cycles, rsp_rdata=0x0031, rsp_valid at cycle 4.
REQ-040 Reset pulled low during HOLD of a wide write -> all outputs 0 immediately, no rsp_valid, no second strobe, cmd_ready=1 after release.
REQ-041 With BUS_INITIATOR_WAIT_EN, bus_wait high for 2 cycles on a byte write -> bus_write high 3 cycles, rsp_valid at cycle 5.
